// File: rtl/rv0_fwb.sv
// Floating-point writeback stage: 2/4-entry result FIFO feeding the FP and shared integer write ports.
// Optional RV0_FWB_BYPASS_EN lets an FP result arriving at an empty FIFO write the FPR in its push cycle.
module rv0_fwb #(
    parameter int XLEN  = 32,
    parameter int FLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_res_vld,
    output logic            exu_res_rdy,
    input  logic [FLEN-1:0] exu_res_data,
    input  logic [4:0]      exu_res_rd,
    input  logic            exu_res_dst_x,
    input  logic [4:0]      exu_res_fflags,
    input  logic            flush,
    output logic            fpr_wr_en,
    output logic [4:0]      fpr_wr_addr,
    output logic [FLEN-1:0] fpr_wr_data,
    output logic            xrf_wr_req,
    input  logic            xrf_wr_gnt,
    output logic [4:0]      xrf_wr_addr,
    output logic [XLEN-1:0] xrf_wr_data,
    input  logic            csr_fflags_we,
    input  logic [4:0]      csr_fflags_wdata,
    output logic [4:0]      fflags,
    output logic            fwb_pend
);

    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);

    logic [FLEN-1:0] mem_data  [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic            mem_dst_x [DEPTH];
    logic [4:0]      mem_flags [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic            head_vld;
    logic [FLEN-1:0] head_data;
    logic [4:0]      head_rd;
    logic            head_dst_x;
    logic [4:0]      head_flags;
    logic            offer;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [4:0]      popped_flags;

    assign exu_res_rdy = (count != FULL);
    assign fwb_pend    = (count != '0);

    assign head_vld   = (count != '0);
    assign head_data  = mem_data[rd_ptr];
    assign head_rd    = mem_rd[rd_ptr];
    assign head_dst_x = mem_dst_x[rd_ptr];
    assign head_flags = mem_flags[rd_ptr];

    assign offer = rst_n && !flush && exu_res_vld && exu_res_rdy;

`ifdef RV0_FWB_BYPASS_EN
    // Only an empty FIFO may be bypassed, otherwise writes would retire out of order.
    assign bypass = offer && !exu_res_dst_x && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = offer && !bypass;

    // Integer heads with rd==0 retire silently; rd!=0 heads wait for the shared port.
    always_comb begin
        pop = 1'b0;
        if (rst_n && !flush && head_vld) begin
            if (!head_dst_x)
                pop = 1'b1;
            else if (head_rd == 5'd0)
                pop = 1'b1;
            else
                pop = xrf_wr_gnt;
        end
    end

    assign popped_flags = pop    ? head_flags :
                          bypass ? exu_res_fflags : 5'd0;

    assign fpr_wr_en   = (rst_n && !flush && head_vld && !head_dst_x) || bypass;
    assign fpr_wr_addr = bypass ? exu_res_rd   : head_rd;
    assign fpr_wr_data = bypass ? exu_res_data : head_data;

    assign xrf_wr_req  = rst_n && !flush && head_vld && head_dst_x && (head_rd != 5'd0);
    assign xrf_wr_addr = head_rd;

    generate
        if (XLEN > FLEN) begin : g_sext
            assign xrf_wr_data = {{(XLEN-FLEN){head_data[FLEN-1]}}, head_data};
        end else begin : g_trunc
            assign xrf_wr_data = head_data[XLEN-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= exu_res_data;
            mem_rd[wr_ptr]    <= exu_res_rd;
            mem_dst_x[wr_ptr] <= exu_res_dst_x;
            mem_flags[wr_ptr] <= exu_res_fflags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= 5'd0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    count <= count + (AW+1)'(1);
                else if (pop && !push)
                    count <= count - (AW+1)'(1);
            end
            if (csr_fflags_we)
                fflags <= csr_fflags_wdata | popped_flags;
            else
                fflags <= fflags | popped_flags;
        end
    end

endmodule

// File: tb/tb_rv0_fwb.sv
// Directed self-checking bench for rv0_fwb (default build, DEPTH=2, XLEN=FLEN=32).
module tb_rv0_fwb;

    logic        clk;
    logic        rst_n;
    logic        exu_res_vld;
    logic        exu_res_rdy;
    logic [31:0] exu_res_data;
    logic [4:0]  exu_res_rd;
    logic        exu_res_dst_x;
    logic [4:0]  exu_res_fflags;
    logic        flush;
    logic        fpr_wr_en;
    logic [4:0]  fpr_wr_addr;
    logic [31:0] fpr_wr_data;
    logic        xrf_wr_req;
    logic        xrf_wr_gnt;
    logic [4:0]  xrf_wr_addr;
    logic [31:0] xrf_wr_data;
    logic        csr_fflags_we;
    logic [4:0]  csr_fflags_wdata;
    logic [4:0]  fflags;
    logic        fwb_pend;

    int n_checks = 0;
    int n_fail   = 0;

    rv0_fwb #(.XLEN(32), .FLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_res_vld(exu_res_vld), .exu_res_rdy(exu_res_rdy),
        .exu_res_data(exu_res_data), .exu_res_rd(exu_res_rd),
        .exu_res_dst_x(exu_res_dst_x), .exu_res_fflags(exu_res_fflags),
        .flush(flush),
        .fpr_wr_en(fpr_wr_en), .fpr_wr_addr(fpr_wr_addr), .fpr_wr_data(fpr_wr_data),
        .xrf_wr_req(xrf_wr_req), .xrf_wr_gnt(xrf_wr_gnt),
        .xrf_wr_addr(xrf_wr_addr), .xrf_wr_data(xrf_wr_data),
        .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
        .fflags(fflags), .fwb_pend(fwb_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic [4:0] rd,
                                 input logic dst_x, input logic [4:0] flags);
        exu_res_vld    = vld;
        exu_res_data   = data;
        exu_res_rd     = rd;
        exu_res_dst_x  = dst_x;
        exu_res_fflags = flags;
        #1;
    endtask

    // Advance one clock and settle 1 time unit past the edge before driving/checking.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        xrf_wr_gnt = 1'b0;
        csr_fflags_we = 1'b0;
        csr_fflags_wdata = 5'd0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        stepCycle();
        stepCycle();
        checkOutput("rst_fpr_en", 32'(fpr_wr_en), 32'd0);
        checkOutput("rst_xrf_req", 32'(xrf_wr_req), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_rdy", 32'(exu_res_rdy), 32'd1);
        checkOutput("rst_pend", 32'(fwb_pend), 32'd0);
        checkOutput("rst_fflags", 32'(fflags), 32'd0);
        checkOutput("rst_fpr_en2", 32'(fpr_wr_en), 32'd0);

        // FP result: write one cycle after push, flags visible the cycle after that.
        stepCycle();
        applyStimulus(1'b1, 32'h3F800000, 5'd5, 1'b0, 5'h01);
        checkOutput("fp_no_lat0", 32'(fpr_wr_en), 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        checkOutput("fp_wr_en", 32'(fpr_wr_en), 32'd1);
        checkOutput("fp_wr_addr", 32'(fpr_wr_addr), 32'd5);
        checkOutput("fp_wr_data", fpr_wr_data, 32'h3F800000);
        checkOutput("fp_pend", 32'(fwb_pend), 32'd1);
        checkOutput("fp_flags_pre", 32'(fflags), 32'd0);
        stepCycle();
        checkOutput("fp_flags", 32'(fflags), 32'h01);
        checkOutput("fp_idle", 32'(fpr_wr_en), 32'd0);
        checkOutput("fp_pend_clr", 32'(fwb_pend), 32'd0);

        // Integer result stalled on grant, FP result queued behind it fills the FIFO.
        applyStimulus(1'b1, 32'hFFFFFFFF, 5'd10, 1'b1, 5'd0);
        stepCycle();
        applyStimulus(1'b1, 32'h40000000, 5'd7, 1'b0, 5'h02);
        for (int i = 0; i < 3; i++) begin
            checkOutput("int_req", 32'(xrf_wr_req), 32'd1);
            checkOutput("int_addr", 32'(xrf_wr_addr), 32'd10);
            checkOutput("int_data", xrf_wr_data, 32'hFFFFFFFF);
            checkOutput("int_no_fpr", 32'(fpr_wr_en), 32'd0);
            if (i > 0) checkOutput("full_rdy", 32'(exu_res_rdy), 32'd0);
            stepCycle();
            applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        end
        xrf_wr_gnt = 1'b1;
        #1;
        checkOutput("gnt_req", 32'(xrf_wr_req), 32'd1);
        checkOutput("full_pop_rdy", 32'(exu_res_rdy), 32'd0);
        stepCycle();
        xrf_wr_gnt = 1'b0;
        #1;
        checkOutput("after_pop_rdy", 32'(exu_res_rdy), 32'd1);
        checkOutput("after_pop_req", 32'(xrf_wr_req), 32'd0);
        checkOutput("q_fp_en", 32'(fpr_wr_en), 32'd1);
        checkOutput("q_fp_addr", 32'(fpr_wr_addr), 32'd7);
        checkOutput("q_fp_data", fpr_wr_data, 32'h40000000);
        stepCycle();
        checkOutput("q_flags", 32'(fflags), 32'h03);

        // Integer result to x0: no request, flags still accrue.
        applyStimulus(1'b1, 32'h12345678, 5'd0, 1'b1, 5'h10);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_req", 32'(xrf_wr_req), 32'd0);
        checkOutput("x0_fpr", 32'(fpr_wr_en), 32'd0);
        checkOutput("x0_pend", 32'(fwb_pend), 32'd1);
        stepCycle();
        checkOutput("x0_flags", 32'(fflags), 32'h13);
        checkOutput("x0_pend_clr", 32'(fwb_pend), 32'd0);

        // Flush with two buffered results plus an offered input.
        applyStimulus(1'b1, 32'h11111111, 5'd3, 1'b1, 5'h04);
        stepCycle();
        applyStimulus(1'b1, 32'h22222222, 5'd4, 1'b1, 5'h02);
        stepCycle();
        flush = 1'b1;
        applyStimulus(1'b1, 32'h33333333, 5'd6, 1'b0, 5'h08);
        checkOutput("fl_req", 32'(xrf_wr_req), 32'd0);
        checkOutput("fl_fpr", 32'(fpr_wr_en), 32'd0);
        stepCycle();
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        checkOutput("fl_pend", 32'(fwb_pend), 32'd0);
        checkOutput("fl_rdy", 32'(exu_res_rdy), 32'd1);
        checkOutput("fl_req2", 32'(xrf_wr_req), 32'd0);
        checkOutput("fl_fpr2", 32'(fpr_wr_en), 32'd0);
        checkOutput("fl_flags", 32'(fflags), 32'h13);

        // CSR write colliding with a pop: wdata OR popped flags.
        csr_fflags_we = 1'b1;
        csr_fflags_wdata = 5'h10;
        stepCycle();
        csr_fflags_we = 1'b0;
        #1;
        checkOutput("csr_wr", 32'(fflags), 32'h10);
        applyStimulus(1'b1, 32'h44444444, 5'd8, 1'b0, 5'h01);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        csr_fflags_we = 1'b1;
        csr_fflags_wdata = 5'h08;
        #1;
        checkOutput("csr_pop_en", 32'(fpr_wr_en), 32'd1);
        stepCycle();
        csr_fflags_we = 1'b0;
        #1;
        checkOutput("csr_pop_flags", 32'(fflags), 32'h09);

        // Back-to-back FP pushes: one write per cycle, in order, rdy never drops.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 5'(i + 1), 1'b0, 5'd0);
            checkOutput("b2b_rdy", 32'(exu_res_rdy), 32'd1);
            if (i > 0) begin
                checkOutput("b2b_en", 32'(fpr_wr_en), 32'd1);
                checkOutput("b2b_addr", 32'(fpr_wr_addr), 32'(i));
                checkOutput("b2b_data", fpr_wr_data, 32'h1000 + 32'(i - 1));
            end
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        checkOutput("b2b_last_addr", 32'(fpr_wr_addr), 32'd6);
        checkOutput("b2b_last_data", fpr_wr_data, 32'h1005);
        stepCycle();
        checkOutput("b2b_drain", 32'(fwb_pend), 32'd0);

        // Reset while an integer result waits: no request in the reset cycle.
        applyStimulus(1'b1, 32'h55555555, 5'd9, 1'b1, 5'h04);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
        checkOutput("mid_req", 32'(xrf_wr_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(xrf_wr_req), 32'd0);
        stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_pend", 32'(fwb_pend), 32'd0);
        checkOutput("mid_rst_flags", 32'(fflags), 32'd0);
        checkOutput("mid_rst_req2", 32'(xrf_wr_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv0_fwb.md
Name: rv0_fwb

Overview:
- Floating-point writeback stage, directly downstream of rv0_exu_f.
- Accepts completed FP results over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Retires each result in order: FP-destination results write the FP register file; integer-destination results (fmv.x.w, fcvt.w.s, feq/flt/fle, fclass) arbitrate for the shared integer register-file write port.
- Accrues exception flags into the fcsr.fflags field.

Parameters:
- XLEN, 32, integer register width.
- FLEN, 32, FP register/result width.
- DEPTH, 2, result FIFO depth; legal values 2 or 4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- exu_res_vld  in  1  result valid from rv0_exu_f
- exu_res_rdy  out  1  FIFO can accept a result
- exu_res_data  in  FLEN  result value
- exu_res_rd  in  5  destination register index
- exu_res_dst_x  in  1  1 = integer destination, 0 = FP destination
- exu_res_fflags  in  5  NV,DZ,OF,UF,NX raised by this op
- flush  in  1  pipeline flush; discard all buffered results
- fpr_wr_en  out  1  FP register file write enable
- fpr_wr_addr  out  5  FP write index
- fpr_wr_data  out  FLEN  FP write data
- xrf_wr_req  out  1  integer write-port request
- xrf_wr_gnt  in  1  integer write-port grant (same cycle)
- xrf_wr_addr  out  5  integer write index
- xrf_wr_data  out  XLEN  integer write data
- csr_fflags_we  in  1  CSR write to fflags/fcsr
- csr_fflags_wdata  in  5  CSR write value
- fflags  out  5  accrued exception flags
- fwb_pend  out  1  at least one result is buffered (scoreboard hold)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values: FIFO empty; occupancy count 0; fflags=0; exu_res_rdy=1; all write enables/requests 0; fwb_pend=0.
- Push: a push occurs when exu_res_vld && exu_res_rdy && !flush. exu_res_rdy = (count != DEPTH) and is registered-state derived, never combinational from exu_res_vld.
- Pop/head: the head entry is presented combinationally from FIFO storage. Earliest write is the cycle after the push (latency 1).
- FP head (dst_x=0): fpr_wr_en=1 and pop in the same cycle. f0 is a real register and is written.
- Integer head, rd!=0: xrf_wr_req=1. Pop only when xrf_wr_gnt=1; otherwise hold the head and keep the request asserted with stable addr/data.
- Integer head, rd==0: pop with no request and no write; fflags are still accrued.
- Integer width: if XLEN>FLEN, sign-extend from bit FLEN-1; if XLEN<=FLEN, take the low XLEN bits.
- Simultaneous push and pop: count is unchanged; a full FIFO with a pop in the same cycle still deasserts rdy that cycle (no pass-through when full).
- Pointers: wrap modulo DEPTH. Count range 0..DEPTH; no overflow or underflow possible.
- fflags update, next value:
  - csr_fflags_we=1: csr_fflags_wdata | popped_flags.
  - Otherwise: fflags | popped_flags.
  - popped_flags = head fflags if a pop occurs this cycle, else 0. Flags are accrued only on pop, never on push.
- Flush:
  - No pop and no write in the flush cycle; fpr_wr_en and xrf_wr_req are forced 0.
  - The FIFO is empty the next cycle.
  - Flags of discarded entries are not accrued.
  - An input offered in the same cycle is dropped.
  - CSR write still applies.
- fwb_pend = (count != 0).
- Reset mid-operation: discard all entries; no writes issued in the reset cycle.

Optional Feature:
- RV0_FWB_BYPASS_EN defined: when the FIFO is empty, a pushed FP-destination result with no flush writes the FPR in the push cycle (latency 0) and is not stored; flags accrue that cycle.
  - Integer-destination results always go through the FIFO.
  - fwb_pend is not asserted for bypassed results.
- Macro undefined: every result is stored first; latency is always at least 1.

Test Plan:
- Reset, then push FP result data=0x3F800000 rd=5 fflags=0x01 at cycle N -> fpr_wr_en=1, addr=5, data=0x3F800000 at N+1; fflags=0x01 at N+2. With RV0_FWB_BYPASS_EN the write occurs at N.
- Push integer result rd=10 data=0xFFFFFFFF with xrf_wr_gnt held 0 for 3 cycles -> xrf_wr_req stable with addr=10, data=0xFFFFFFFF; pop on grant; a second FP push then fills the FIFO and exu_res_rdy=0 until the pop.
- Integer result rd=0 fflags=0x10 -> no xrf_wr_req; fflags=0x10 after pop.
- Two buffered results with fflags 0x04 and 0x02, flush asserted before either pops -> no writes; FIFO empty and fwb_pend=0 next cycle; fflags unchanged.
- csr_fflags_we with wdata=0x08 in the same cycle as a pop with flags 0x01, prior fflags=0x10 -> fflags=0x09.
- Back-to-back pushes every cycle with FP destinations -> one FPR write per cycle, in order, and exu_res_rdy never drops.
